// File: rtl/uart_core_param.sv
// Single-clock UART transceiver with configurable width, parity, stop bits and oversampled RX.
// TX takes words through a valid/ready handshake. RX syncs the line and takes a 3-sample majority per bit.
module uart_core_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cfg_par_en,
  input  logic                      cfg_par_typ,
  input  logic                      cfg_stop2,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_busy,
  output logic                      tx_out,
  input  logic                      rx_in,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_valid,
  output logic                      parity_error,
  output logic                      framing_error
);

  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Prescale values below 4 leave no room for three samples around mid-bit.
  logic [PRESCALE_WIDTH-1:0] p_cfg;
  assign p_cfg = (cfg_prescale < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : cfg_prescale;

  // ---------------- TX ----------------
  tx_state_t                 tx_state_q, tx_state_d;
  logic [PRESCALE_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [PRESCALE_WIDTH-1:0] tx_p_q, tx_p_d;
  logic [BW-1:0]             tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0]     tx_shift_q, tx_shift_d;
  logic                      tx_par_en_q, tx_par_en_d;
  logic                      tx_stop2_q, tx_stop2_d;
  logic                      tx_par_q, tx_par_d;
  logic                      tx_cnt_last;

  assign tx_cnt_last = (tx_cnt_q == tx_p_q - PRESCALE_WIDTH'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_p_q      <= PRESCALE_WIDTH'(4);
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_par_q    <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_p_q      <= tx_p_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_en_q <= tx_par_en_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_par_q    <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_p_d      = tx_p_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_par_d    = tx_par_q;
    if (tx_state_q == TX_IDLE) begin
      if (tx_valid) begin
        tx_state_d  = TX_START;
        tx_cnt_d    = '0;
        tx_bit_d    = '0;
        tx_shift_d  = tx_data;
        tx_p_d      = p_cfg;
        tx_par_en_d = cfg_par_en;
        tx_stop2_d  = cfg_stop2;
        tx_par_d    = (^tx_data) ^ cfg_par_typ;
      end
    end else if (tx_cnt_last) begin
      tx_cnt_d = '0;
      case (tx_state_q)
        TX_START:  tx_state_d = TX_DATA;
        TX_DATA: begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + BW'(1);
          if (tx_bit_q == BW'(DATA_WIDTH - 1))
            tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
        end
        TX_PARITY: tx_state_d = TX_STOP1;
        TX_STOP1:  tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
        default:   tx_state_d = TX_IDLE;
      endcase
    end else begin
      tx_cnt_d = tx_cnt_q + PRESCALE_WIDTH'(1);
    end
  end

  // Line level is decoded straight from the state so reset drives it high at once.
  always_comb begin
    tx_ready = (tx_state_q == TX_IDLE);
    tx_busy  = (tx_state_q != TX_IDLE);
    case (tx_state_q)
      TX_START:  tx_out = 1'b0;
      TX_DATA:   tx_out = tx_shift_q[0];
      TX_PARITY: tx_out = tx_par_q;
      default:   tx_out = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  rx_state_t                 rx_state_q, rx_state_d;
  logic                      rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [PRESCALE_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [PRESCALE_WIDTH-1:0] rx_p_q, rx_p_d;
  logic [BW-1:0]             rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0]     rx_shift_q, rx_shift_d;
  logic                      rx_par_en_q, rx_par_en_d;
  logic                      rx_par_typ_q, rx_par_typ_d;
  logic                      rx_par_bit_q, rx_par_bit_d;
  logic                      rx_smp0_q, rx_smp0_d, rx_smp1_q, rx_smp1_d;
  logic [DATA_WIDTH-1:0]     rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      rx_perr_q, rx_perr_d;
  logic                      rx_ferr_q, rx_ferr_d;
  logic [PRESCALE_WIDTH-1:0] rx_c0, rx_c1, rx_c2;
  logic                      rx_cnt_last, rx_maj, rx_par_bad;

  assign rx_c1       = rx_p_q >> 1;
  assign rx_c0       = rx_c1 - PRESCALE_WIDTH'(1);
  assign rx_c2       = rx_c1 + PRESCALE_WIDTH'(1);
  assign rx_cnt_last = (rx_cnt_q == rx_p_q - PRESCALE_WIDTH'(1));
  assign rx_maj      = (rx_smp0_q & rx_smp1_q) | (rx_smp0_q & rx_s2_q) | (rx_smp1_q & rx_s2_q);
  assign rx_par_bad  = rx_par_en_q & ((^rx_shift_q) ^ rx_par_typ_q ^ rx_par_bit_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_state_q   <= RX_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_p_q       <= PRESCALE_WIDTH'(4);
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_typ_q <= 1'b0;
      rx_par_bit_q <= 1'b0;
      rx_smp0_q    <= 1'b1;
      rx_smp1_q    <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_p_q       <= rx_p_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_typ_q <= rx_par_typ_d;
      rx_par_bit_q <= rx_par_bit_d;
      rx_smp0_q    <= rx_smp0_d;
      rx_smp1_q    <= rx_smp1_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_s1_d      = rx_in;
    rx_s2_d      = rx_s1_q;
    rx_prev_d    = rx_s2_q;
    rx_cnt_d     = rx_cnt_q;
    rx_p_d       = rx_p_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_typ_d = rx_par_typ_q;
    rx_par_bit_d = rx_par_bit_q;
    rx_smp0_d    = rx_smp0_q;
    rx_smp1_d    = rx_smp1_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_perr_d    = 1'b0;
    rx_ferr_d    = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      // The detection cycle is the first low sample, i.e. count 0 of the start bit.
      if (rx_prev_q && !rx_s2_q) begin
        rx_state_d   = RX_START;
        rx_cnt_d     = PRESCALE_WIDTH'(1);
        rx_bit_d     = '0;
        rx_p_d       = p_cfg;
        rx_par_en_d  = cfg_par_en;
        rx_par_typ_d = cfg_par_typ;
      end
    end else begin
      rx_cnt_d = rx_cnt_last ? '0 : rx_cnt_q + PRESCALE_WIDTH'(1);
      if (rx_cnt_q == rx_c0) rx_smp0_d = rx_s2_q;
      if (rx_cnt_q == rx_c1) rx_smp1_d = rx_s2_q;
      if (rx_cnt_last) begin
        case (rx_state_q)
          RX_START: rx_state_d = RX_DATA;
          RX_DATA: begin
            rx_bit_d = rx_bit_q + BW'(1);
            if (rx_bit_q == BW'(DATA_WIDTH - 1))
              rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
          end
          RX_PARITY: rx_state_d = RX_STOP;
          default: begin end
        endcase
      end
      // Majority decisions come after bit advance so a glitch or stop return to IDLE wins.
      if (rx_cnt_q == rx_c2) begin
        case (rx_state_q)
          RX_START:  if (rx_maj) rx_state_d = RX_IDLE;
          RX_DATA:   rx_shift_d = {rx_maj, rx_shift_q[DATA_WIDTH-1:1]};
          RX_PARITY: rx_par_bit_d = rx_maj;
          RX_STOP: begin
            rx_state_d = RX_IDLE;
            rx_data_d  = rx_shift_q;
            rx_perr_d  = rx_par_bad;
            rx_ferr_d  = !rx_maj;
            rx_valid_d = !rx_par_bad && rx_maj;
          end
          default: begin end
        endcase
      end
    end
  end

  always_comb begin
    rx_data       = rx_data_q;
    rx_valid      = rx_valid_q;
    parity_error  = rx_perr_q;
    framing_error = rx_ferr_q;
  end

endmodule
